// File: rtl/imem_waitstate.sv
// imem_waitstate: synchronous LEGv8 instruction memory with a req/ready fetch
// handshake, configurable wait states, a run-time program port and a fetch counter.
module imem_waitstate #(
  parameter int N           = 32,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W+1:0] addr,
  output logic              ready,
  output logic              valid,
  output logic [N-1:0]      q,
  output logic              err,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [N-1:0]      prog_data,
  output logic [15:0]       fetch_cnt
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("imem_waitstate: WAIT_STATES must lie in 0..15");
  end

  localparam bit        NO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] WS_LAST = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                mis_q, mis_d;
  logic [15:0]         fetch_cnt_q, fetch_cnt_d;

  logic [N-1:0]        mem [2**ADDR_W];
  logic [N-1:0]        rd_data_q;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;

  logic [ADDR_W-1:0]   addr_idx;
  logic                addr_mis;

  assign addr_idx = addr[ADDR_W+1:2];
  assign addr_mis = |addr[1:0];

  // RESP behaves like IDLE for acceptance, so a held req chains fetches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    rd_en   = 1'b0;
    rd_addr = idx_q;
    ready   = 1'b0;
    valid   = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        ready = 1'b1;
        valid = (state_q == ST_RESP);
        if (req) begin
          idx_d = addr_idx;
          mis_d = addr_mis;
          if (NO_WAIT) begin
            state_d = ST_RESP;
            rd_en   = 1'b1;
            rd_addr = addr_idx;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS_LAST;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          rd_en   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    if (valid && !mis_q && fetch_cnt_q != 16'hFFFF) begin
      fetch_cnt_d = fetch_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= '0;
      mis_q       <= 1'b0;
      fetch_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      mis_q       <= mis_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // Read and write share an edge; the read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign q         = (valid && !mis_q) ? rd_data_q : '0;
  assign err       = valid && mis_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_imem_waitstate.sv
// Bench for imem_waitstate: a zero-wait and a two-wait instance checked by
// directed scenarios and by random traffic against a due-time reference model.
module tb_imem_waitstate;
  localparam int N  = 32;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [AW+1:0]   addr;
  logic            req_s [2];
  logic            prog_we;
  logic [AW-1:0]   prog_addr;
  logic [N-1:0]    prog_data;
  logic            rdy  [2];
  logic            vld  [2];
  logic            erro [2];
  logic [N-1:0]    qo   [2];
  logic [15:0]     cnto [2];

  imem_waitstate #(.N(N), .ADDR_W(AW), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req_s[0]), .addr(addr), .ready(rdy[0]),
    .valid(vld[0]), .q(qo[0]), .err(erro[0]), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .fetch_cnt(cnto[0])
  );

  imem_waitstate #(.N(N), .ADDR_W(AW), .WAIT_STATES(2)) dut2 (
    .clk(clk), .reset(reset), .req(req_s[1]), .addr(addr), .ready(rdy[1]),
    .valid(vld[1]), .q(qo[1]), .err(erro[1]), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .fetch_cnt(cnto[1])
  );

  // Reference model: a fetch accepted at edge e responds in the cycle after edge e+WS.
  logic [N-1:0] model_mem [256];
  bit           pend [2];
  int           due  [2];
  int           pidx [2];
  bit           pmis [2];
  bit           e_ready [2];
  bit           e_valid [2];
  bit           e_err   [2];
  logic [N-1:0] e_q     [2];
  int           e_cnt   [2];
  int           edge_n = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    edge_n++;
    for (int m = 0; m < 2; m++) begin
      if (reset) begin
        pend[m] = 1'b0; e_ready[m] = 1'b1; e_valid[m] = 1'b0;
        e_err[m] = 1'b0; e_q[m] = '0; e_cnt[m] = 0;
      end else begin
        if (e_valid[m] && !e_err[m] && e_cnt[m] < 65535) e_cnt[m]++;
        if (req_s[m] && e_ready[m]) begin
          pend[m] = 1'b1;
          due[m]  = edge_n + ((m == 1) ? 2 : 0);
          pidx[m] = int'(addr[AW+1:2]);
          pmis[m] = (addr[1:0] != 2'b00);
        end
        e_valid[m] = 1'b0; e_err[m] = 1'b0; e_q[m] = '0;
        if (pend[m] && due[m] == edge_n) begin
          pend[m]    = 1'b0;
          e_valid[m] = 1'b1;
          e_err[m]   = pmis[m];
          e_q[m]     = pmis[m] ? '0 : model_mem[pidx[m]];
        end
        e_ready[m] = !pend[m];
      end
    end
    if (prog_we) model_mem[prog_addr] = prog_data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    for (int m = 0; m < 2; m++) begin
      n_checks++; if (rdy[m] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b want 1", m, rdy[m]); end
      n_checks++; if (vld[m] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b want 0", m, vld[m]); end
      n_checks++; if (qo[m] !== 32'h0) begin n_fail++; $display("FAIL reset_q[%0d]: got %h want 0", m, qo[m]); end
      n_checks++; if (erro[m] !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b want 0", m, erro[m]); end
      n_checks++; if (cnto[m] !== 16'd0) begin n_fail++; $display("FAIL reset_cnt[%0d]: got %0d want 0", m, cnto[m]); end
    end
    reset = 1'b0;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 256; i++) begin
      prog_we = 1'b1; prog_addr = 8'(i); prog_data = $urandom;
      tick();
    end
    prog_we = 1'b0;
  endtask

  task automatic test_first_fetch();
    prog_we = 1'b1; prog_addr = 8'd0; prog_data = 32'hf8000001; tick();
    prog_addr = 8'd1; prog_data = 32'hf8008002; tick();
    prog_we = 1'b0;
    req_s[1] = 1'b1; addr = 10'd0; tick();
    req_s[1] = 1'b0;
    n_checks++; if (rdy[1] !== 1'b0) begin n_fail++; $display("FAIL first_ready_c1: got %b want 0", rdy[1]); end
    tick();
    n_checks++; if (rdy[1] !== 1'b0) begin n_fail++; $display("FAIL first_ready_c2: got %b want 0", rdy[1]); end
    n_checks++; if (vld[1] !== 1'b0) begin n_fail++; $display("FAIL first_early_valid: got %b want 0", vld[1]); end
    tick();
    n_checks++; if (vld[1] !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b want 1", vld[1]); end
    n_checks++; if (qo[1] !== 32'hf8000001) begin n_fail++; $display("FAIL first_q: got %h want f8000001", qo[1]); end
    n_checks++; if (rdy[1] !== 1'b1) begin n_fail++; $display("FAIL first_resp_ready: got %b want 1", rdy[1]); end
    tick();
    n_checks++; if (vld[1] !== 1'b0 || qo[1] !== 32'h0) begin n_fail++; $display("FAIL first_after: valid %b q %h want 0 0", vld[1], qo[1]); end
    n_checks++; if (cnto[1] !== 16'd1) begin n_fail++; $display("FAIL first_cnt: got %0d want 1", cnto[1]); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] words [3];
    int  k = 0;
    bit  acc, exp_v;
    for (int i = 0; i < 3; i++) words[i] = model_mem[i];
    for (int i = 1; i <= 10; i++) begin
      req_s[1] = (k < 3);
      addr = 10'(k * 4);
      acc = req_s[1] && e_ready[1];
      tick();
      if (acc) k++;
      exp_v = (i % 3 == 0) && (i <= 9);
      n_checks++; if (vld[1] !== exp_v) begin n_fail++; $display("FAIL b2b_valid cyc %0d: got %b want %b", i, vld[1], exp_v); end
      if (exp_v) begin
        n_checks++; if (qo[1] !== words[i/3-1]) begin n_fail++; $display("FAIL b2b_q cyc %0d: got %h want %h", i, qo[1], words[i/3-1]); end
      end
    end
    req_s[1] = 1'b0;
    n_checks++; if (cnto[1] !== 16'd4) begin n_fail++; $display("FAIL b2b_cnt: got %0d want 4", cnto[1]); end
  endtask

  task automatic test_no_wait();
    req_s[0] = 1'b1; addr = 10'd4; tick();
    req_s[0] = 1'b0;
    n_checks++; if (vld[0] !== 1'b1) begin n_fail++; $display("FAIL nowait_valid: got %b want 1", vld[0]); end
    n_checks++; if (qo[0] !== 32'hf8008002) begin n_fail++; $display("FAIL nowait_q: got %h want f8008002", qo[0]); end
    tick();
    n_checks++; if (vld[0] !== 1'b0) begin n_fail++; $display("FAIL nowait_drop: got %b want 0", vld[0]); end
    req_s[0] = 1'b1; addr = 10'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (vld[0] !== 1'b1 || qo[0] !== 32'hf8000001) begin n_fail++; $display("FAIL nowait_stream %0d: valid %b q %h want 1 f8000001", i, vld[0], qo[0]); end
    end
    req_s[0] = 1'b0;
    tick();
    n_checks++; if (cnto[0] !== 16'd5) begin n_fail++; $display("FAIL nowait_cnt: got %0d want 5", cnto[0]); end
  endtask

  task automatic test_misaligned();
    req_s[1] = 1'b1; addr = 10'd6; tick();
    req_s[1] = 1'b0;
    tick();
    n_checks++; if (vld[1] !== 1'b0) begin n_fail++; $display("FAIL mis_early: got %b want 0", vld[1]); end
    tick();
    n_checks++; if (vld[1] !== 1'b1 || erro[1] !== 1'b1) begin n_fail++; $display("FAIL mis_flags: valid %b err %b want 1 1", vld[1], erro[1]); end
    n_checks++; if (qo[1] !== 32'h0) begin n_fail++; $display("FAIL mis_q: got %h want 0", qo[1]); end
    tick();
    n_checks++; if (cnto[1] !== 16'd4 || erro[1] !== 1'b0) begin n_fail++; $display("FAIL mis_after: cnt %0d err %b want 4 0", cnto[1], erro[1]); end
  endtask

  task automatic test_rbw();
    req_s[1] = 1'b1; addr = 10'd4; tick();
    req_s[1] = 1'b0; tick();
    prog_we = 1'b1; prog_addr = 8'd1; prog_data = 32'hb400001f; tick();
    prog_we = 1'b0;
    n_checks++; if (vld[1] !== 1'b1 || qo[1] !== 32'hf8008002) begin n_fail++; $display("FAIL rbw_old: valid %b q %h want 1 f8008002", vld[1], qo[1]); end
    tick();
    req_s[1] = 1'b1; addr = 10'd4; tick();
    req_s[1] = 1'b0; tick(); tick();
    n_checks++; if (vld[1] !== 1'b1 || qo[1] !== 32'hb400001f) begin n_fail++; $display("FAIL rbw_new: valid %b q %h want 1 b400001f", vld[1], qo[1]); end
    tick();
  endtask

  task automatic test_reset_abort();
    req_s[1] = 1'b1; addr = 10'd0; tick();
    req_s[1] = 1'b0; reset = 1'b1; tick();
    reset = 1'b0;
    n_checks++; if (rdy[1] !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", rdy[1]); end
    n_checks++; if (cnto[1] !== 16'd0 || cnto[0] !== 16'd0) begin n_fail++; $display("FAIL abort_cnt: got %0d/%0d want 0/0", cnto[1], cnto[0]); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (vld[1] !== 1'b0) begin n_fail++; $display("FAIL abort_valid %0d: got %b want 0", i, vld[1]); end
      tick();
    end
    req_s[1] = 1'b1; addr = 10'd4; tick();
    req_s[1] = 1'b0; tick(); tick();
    n_checks++; if (vld[1] !== 1'b1 || qo[1] !== 32'hb400001f) begin n_fail++; $display("FAIL abort_mem_kept: valid %b q %h want 1 b400001f", vld[1], qo[1]); end
    tick();
  endtask

  task automatic test_random();
    logic [AW+1:0] a;
    for (int blk = 0; blk < 8; blk++) begin
      int m = blk % 2;
      for (int c = 0; c < 60; c++) begin
        req_s[m] = (c < 54) && ($urandom_range(0, 3) != 0);
        a = {8'($urandom_range(0, 7)), 2'b00};
        if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
        addr = a;
        prog_we   = ($urandom_range(0, 2) == 0);
        prog_addr = 8'($urandom_range(0, 7));
        prog_data = $urandom;
        tick();
        n_checks++; if (rdy[m] !== e_ready[m]) begin n_fail++; $display("FAIL rnd_ready dut%0d t%0d: got %b want %b", m, edge_n, rdy[m], e_ready[m]); end
        n_checks++; if (vld[m] !== e_valid[m]) begin n_fail++; $display("FAIL rnd_valid dut%0d t%0d: got %b want %b", m, edge_n, vld[m], e_valid[m]); end
        n_checks++; if (erro[m] !== e_err[m]) begin n_fail++; $display("FAIL rnd_err dut%0d t%0d: got %b want %b", m, edge_n, erro[m], e_err[m]); end
        n_checks++; if (qo[m] !== e_q[m]) begin n_fail++; $display("FAIL rnd_q dut%0d t%0d: got %h want %h", m, edge_n, qo[m], e_q[m]); end
        n_checks++; if (cnto[m] !== 16'(e_cnt[m])) begin n_fail++; $display("FAIL rnd_cnt dut%0d t%0d: got %0d want %0d", m, edge_n, cnto[m], e_cnt[m]); end
      end
      req_s[m] = 1'b0;
      prog_we  = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; addr = '0; req_s[0] = 1'b0; req_s[1] = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; e_ready[m] = 1'b1; e_valid[m] = 1'b0;
      e_err[m] = 1'b0; e_q[m] = '0; e_cnt[m] = 0;
    end
    test_reset();
    load_mem();
    test_first_fetch();
    test_back_to_back();
    test_no_wait();
    test_misaligned();
    test_rbw();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
